// File: rtl/data_memory_unit.sv
// Multi-cycle LD/SD data memory with a fixed access latency and a valid/ready handshake.
// Illegal requests are answered one cycle after accept with err set and no memory access.
//
// state  | meaning
// IDLE   | ready; a request is accepted on the next edge when req_valid_i is high
// ACCESS | legal access in flight; down-counter reaches zero on the last cycle
// RESP   | one-cycle response: rsp_valid_o high, err_o/read_data_o valid
module data_memory_unit #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [63:0] address_i,
  input  logic [63:0] write_data_i,
  output logic [63:0] read_data_o,
  output logic        rsp_valid_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [63:0]        wdata_q;
  logic               wr_q;
  logic [63:0]        read_data_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic [63:0]        mem_q [DEPTH];

  logic req_illegal;
  logic mem_we;

  // Anything outside the doubleword-aligned window of the array is rejected.
  assign req_illegal = (mem_read_i == mem_write_i)
                     || (address_i[2:0] != 3'b000)
                     || (address_i[63:3+IDX_W] != '0);

  assign mem_we = (state_q == S_ACCESS) && (cnt_q == '0) && wr_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
          if (req_valid_i) begin
            idx_q   <= address_i[3+IDX_W-1:3];
            wdata_q <= write_data_i;
            wr_q    <= mem_write_i;
            if (req_illegal) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
              read_data_q <= '0;
            end else begin
              state_q <= S_ACCESS;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b0;
            if (!wr_q) read_data_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; an async reset drops state_q so a pending store never commits.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_o     = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_ACCESS);
  assign read_data_o = read_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit (DEPTH=32, LATENCY=2): handshake timing, errors,
// mid-access reset and a streaming store/load sweep over every word.
module tb_data_memory_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        rsp_valid;
  logic        err;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_mem [32];
  logic [63:0] exp_rd;

  data_memory_unit #(.DEPTH(32), .LATENCY(LAT)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .address_i    (address),
    .write_data_i (write_data),
    .read_data_o  (read_data),
    .rsp_valid_o  (rsp_valid),
    .err_o        (err),
    .stall_o      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE; expectations come from exp_err and the bench memory model.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic exp_err);
    int c;
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    #1;
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    check({tag, " stall0"}, 64'(stall), 64'd1);
    step();
    req_valid  = 1'b0;
    mem_read   = ~rd;
    address    = 64'hFFFF_FFFF_FFFF_FFF7;
    write_data = ~wdata;
    c = 1;
    while (c <= 8 && !rsp_valid) begin
      check({tag, " stall_acc"}, 64'(stall), 64'd1);
      step();
      c++;
    end
    if (exp_err) exp_rd = 64'd0;
    else if (wr) exp_mem[addr[7:3]] = wdata;
    else exp_rd = exp_mem[addr[7:3]];
    check({tag, " rsp_cycle"}, 64'(c), exp_err ? 64'd1 : 64'(LAT + 1));
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " rdata"}, read_data, exp_rd);
    check({tag, " stall_rsp"}, 64'(stall), 64'd0);
    step();
    check({tag, " rsp_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, " idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int k, r, cyc, w;
    logic pend_wr;
    logic [4:0] pend_idx;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    exp_rd     = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    check("rst ready", 64'(req_ready), 64'd1);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst rdata", read_data, 64'd0);
    check("rst stall", 64'(stall), 64'd0);

    do_req("t1 sd", 1'b0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_req("t1 ld", 1'b1, 1'b0, 64'h10, 64'h0, 1'b0);
    check("t1 data", read_data, 64'h0123_4567_89AB_CDEF);

    do_req("t2 misalign", 1'b1, 1'b0, 64'h0C, 64'h0, 1'b1);

    do_req("t3 sd0", 1'b0, 1'b1, 64'h00, 64'h1111, 1'b0);
    do_req("t3 ld0a", 1'b1, 1'b0, 64'h00, 64'h0, 1'b0);
    do_req("t3 sd_hold", 1'b0, 1'b1, 64'h20, 64'h2222, 1'b0);
    do_req("t3 oob", 1'b0, 1'b1, 64'h100, 64'hBAD0, 1'b1);
    do_req("t3 ld0b", 1'b1, 1'b0, 64'h00, 64'h0, 1'b0);
    check("t3 data", read_data, 64'h1111);
    do_req("t3 high", 1'b1, 1'b0, 64'h8000_0000_0000_0010, 64'h0, 1'b1);

    do_req("t4 sd8", 1'b0, 1'b1, 64'h08, 64'h0808, 1'b0);
    do_req("t4 both", 1'b1, 1'b1, 64'h08, 64'hDEAD, 1'b1);
    do_req("t4 none", 1'b0, 1'b0, 64'h08, 64'hBEEF, 1'b1);
    do_req("t4 ld8", 1'b1, 1'b0, 64'h08, 64'h0, 1'b0);
    check("t4 data", read_data, 64'h0808);

    do_req("t5 sd", 1'b0, 1'b1, 64'h18, 64'hAAAA, 1'b0);
    do_req("t5 ld", 1'b1, 1'b0, 64'h18, 64'h0, 1'b0);
    req_valid  = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = 64'h18;
    write_data = 64'h5555;
    step();
    req_valid = 1'b0;
    check("t5 in_access", 64'(stall), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t5 rst ready", 64'(req_ready), 64'd1);
    check("t5 rst rsp", 64'(rsp_valid), 64'd0);
    check("t5 rst err", 64'(err), 64'd0);
    check("t5 rst rdata", read_data, 64'd0);
    check("t5 rst stall", 64'(stall), 64'd0);
    #2 reset_n = 1'b1;
    exp_rd = 64'd0;
    step();
    do_req("t5 ld_after", 1'b1, 1'b0, 64'h18, 64'h0, 1'b0);
    check("t5 data", read_data, 64'hAAAA);

    // Streaming: req_valid stays high, SD then LD for each word.
    k = 0;
    r = 0;
    cyc = 0;
    pend_wr = 1'b0;
    pend_idx = '0;
    while (r < 64 && cyc < 600) begin
      if (rsp_valid) begin
        check("t6 err", 64'(err), 64'd0);
        if (!pend_wr) exp_rd = exp_mem[pend_idx];
        r++;
      end
      check("t6 rdata", read_data, exp_rd);
      if (req_ready) begin
        if (k < 64) begin
          w = k / 2;
          pend_idx   = 5'(w);
          pend_wr    = (k % 2) == 0;
          req_valid  = 1'b1;
          mem_write  = pend_wr;
          mem_read   = ~pend_wr;
          address    = 64'(w) << 3;
          write_data = 64'hA5A5_0000_0000_0000 | (64'(w) * 64'h0101_0101);
          if (pend_wr) exp_mem[w] = write_data;
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
    check("t6 responses", 64'(r), 64'd64);
    check("t6 cycles", 64'(cyc), 64'd256);
    repeat (4) begin
      step();
      check("t6 no_extra", 64'(rsp_valid), 64'd0);
    end
    check("t6 last_word", read_data, 64'hA5A5_0000_0000_0000 | (64'd31 * 64'h0101_0101));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
